mod_seq_monitor: RTL

- Receive-side checker for the mod-N counter value bus. Samples a counter output Q_IN and decodes it to one-hot.
- Locks onto a valid up-count sequence, flags wrap-around, and detects and counts sequencing errors.
- Sits downstream of the mod-5 counter in display/sequencing logic; provides a registered decode plus health status.

---
 rtl/mod_seq_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mod_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mod_seq_monitor
// Purpose  : Receive-side checker for a mod-N counter bus. It gives a registered
//            one-hot decode, locks onto an up-count sequence, flags wrap-around,
//            and counts sequencing errors.
// Option   : MON_HOLD_TOLERATE_EN - a repeated value in ACQUIRE/LOCK is a legal hold
// Revision : 1.0 - initial release
// ============================================================================
module mod_seq_monitor #(
  parameter int MODULUS   = 5,
  parameter int WIDTH     = 3,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     Q_IN,
  input  logic                 CLR_ERR,
  output logic [MODULUS-1:0]   ONEHOT,
  output logic                 WRAP,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
);

  localparam int                 MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH:0]     MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0]   MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [MATCH_W-1:0] LOCK_M  = MATCH_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCK    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MODULUS-1:0]   onehot_q, onehot_d;
  logic                 wrap_q, wrap_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] w_cnt_base;

  logic                 w_legal;
  logic [WIDTH-1:0]     w_expected;
  logic                 w_hold;

  // Widened compare so that Q_IN never aliases past 2^WIDTH.
  assign w_legal    = ({1'b0, Q_IN} < MOD_EXT);
  assign w_expected = (ref_q == MAX_VAL) ? '0 : ref_q + WIDTH'(1);

`ifdef MON_HOLD_TOLERATE_EN
  assign w_hold = w_legal && (state_q != ST_SEARCH) && (Q_IN == ref_q);
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    onehot_d = onehot_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    if (EN) begin
      for (int i = 0; i < MODULUS; i++) begin
        onehot_d[i] = w_legal && (Q_IN == WIDTH'(i));
      end
      case (state_q)
        ST_SEARCH: begin
          if (w_legal) begin
            ref_d   = Q_IN;
            match_d = MATCH_W'(1);
            state_d = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (!w_legal) begin
            state_d = ST_SEARCH;
            match_d = '0;
          end else if (w_hold) begin
            state_d = state_q;
          end else if (Q_IN == w_expected) begin
            ref_d   = Q_IN;
            match_d = match_q + MATCH_W'(1);
            if (match_q + MATCH_W'(1) == LOCK_M) state_d = ST_LOCK;
          end else begin
            ref_d   = Q_IN;
            match_d = MATCH_W'(1);
          end
        end
        ST_LOCK: begin
          if (!w_legal) begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
            match_d = '0;
          end else if (w_hold) begin
            state_d = state_q;
          end else if (Q_IN == w_expected) begin
            ref_d  = Q_IN;
            wrap_d = (ref_q == MAX_VAL) && (Q_IN == '0);
          end else begin
            // Reseed from the offending value; LOCK_CNT >= 2 keeps us out of LOCK.
            err_d   = 1'b1;
            ref_d   = Q_IN;
            match_d = MATCH_W'(1);
            state_d = ST_ACQUIRE;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          match_d = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCK);

    // Clear first, then count, so a coincident error leaves the counter at 1.
    w_cnt_base = CLR_ERR ? '0 : err_cnt_q;
    err_cnt_d  = (err_d && (w_cnt_base != '1)) ? w_cnt_base + ERR_CNT_W'(1) : w_cnt_base;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SEARCH;
      ref_q     <= '0;
      match_q   <= '0;
      onehot_q  <= '0;
      wrap_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      onehot_q  <= onehot_d;
      wrap_q    <= wrap_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ONEHOT    = onehot_q;
  assign WRAP      = wrap_q;
  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign ERR_COUNT = err_cnt_q;

endmodule
`default_nettype wire
